// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the access-arbiter state encoding.
package fb_pkg;

   localparam int ADDR_W     = 19;
   localparam int DATA_W     = 6;
   localparam int H_ACTIVE   = 640;
   localparam int V_ACTIVE   = 480;
   localparam int FB_SIZE    = H_ACTIVE * V_ACTIVE;
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      BLANK = 2'd2
   } arb_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO holding queued {addr,data} pixel writes until blanking.
module fb_wr_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [LVL_W-1:0] level_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (level_r == LVL_W'(DEPTH));
   assign empty     = (level_r == {LVL_W{1'b0}});
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign pop_data  = mem_r[rd_ptr_r];
   assign level     = level_r;

   // Storage array: written on push only, never reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + LVL_W'(1);
            2'b01:   level_r <= level_r - LVL_W'(1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/fb_access_arbiter.sv
// Frame-buffer port arbiter: scan-out reads own the port while video_on is high,
// queued pixel writes drain one per cycle during blanking.
module fb_access_arbiter #(
   parameter int ADDR_W     = fb_pkg::ADDR_W,
   parameter int DATA_W     = fb_pkg::DATA_W,
   parameter int FIFO_DEPTH = fb_pkg::FIFO_DEPTH,
   parameter int FB_SIZE    = fb_pkg::FB_SIZE
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          video_on,
   input  logic [ADDR_W-1:0]             rd_addr,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   output logic [ADDR_W-1:0]             fb_addr,
   output logic                          fb_we,
   output logic [DATA_W-1:0]             fb_wdata,
   output logic                          rd_grant,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          addr_err
);

   import fb_pkg::*;

   localparam int                ENTRY_W  = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_SIZE);

   arb_state_t          state_r;
   arb_state_t          state_next_s;
   logic                full_s;
   logic                empty_s;
   logic                accept_s;
   logic                in_range_s;
   logic                push_s;
   logic                pop_s;
   logic [ENTRY_W-1:0]  head_s;

   // Reset gates wr_ready so no write is accepted while the block is held in reset.
   assign wr_ready   = rst & en & ~full_s;
   assign accept_s   = wr_valid & wr_ready;
   assign in_range_s = (wr_addr < FB_LIMIT);
   assign push_s     = accept_s & in_range_s;
   // Pops only while blanking; a rising video_on leaves the head entry queued.
   assign pop_s      = (state_next_s == BLANK) & ~empty_s;

   fb_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data ({wr_addr, wr_data}),
      .pop       (pop_s),
      .pop_data  (head_s),
      .full      (full_s),
      .empty     (empty_s),
      .level     (fifo_level)
   );

   // Next-state selection: scan-out follows video_on with no delay.
   always_comb begin
      state_next_s = IDLE;
      case (state_r)
         IDLE: begin
            if (en) begin
               state_next_s = video_on ? SCAN : BLANK;
            end else begin
               state_next_s = IDLE;
            end
         end
         SCAN, BLANK: begin
            if (!en) begin
               state_next_s = IDLE;
            end else if (video_on) begin
               state_next_s = SCAN;
            end else begin
               state_next_s = BLANK;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register and registered frame-buffer port outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         fb_addr  <= {ADDR_W{1'b0}};
         fb_we    <= 1'b0;
         fb_wdata <= {DATA_W{1'b0}};
         rd_grant <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         state_r <= state_next_s;
         if (accept_s && !in_range_s) begin
            addr_err <= 1'b1;
         end
         case (state_next_s)
            SCAN: begin
               fb_addr  <= rd_addr;
               rd_grant <= 1'b1;
               fb_we    <= 1'b0;
            end
            BLANK: begin
               rd_grant <= 1'b0;
               if (pop_s) begin
                  fb_addr  <= head_s[ENTRY_W-1:DATA_W];
                  fb_wdata <= head_s[DATA_W-1:0];
                  fb_we    <= 1'b1;
               end else begin
                  fb_we    <= 1'b0;
               end
            end
            default: begin
               fb_addr  <= {ADDR_W{1'b0}};
               rd_grant <= 1'b0;
               fb_we    <= 1'b0;
            end
         endcase
      end
   end

endmodule
